wb_serial_divider_v2: RTL and testbench
=======================================

Name: wb_serial_divider_v2

Overview:
- Next-generation Wishbone-mapped iterative divider for the user project area.
- Performs one quotient bit per clock on XLEN-wide operands.
- Adds signed/unsigned mode, divide-by-zero and signed-overflow handling, busy/done status and an interrupt.
- Sits directly on the WB MI A slave port; its operands and results are mirrored onto the logic analyzer bus.

Parameters:
- WBW, 32, Wishbone data/address width; must be 32.
- XLEN, 32, operand and result width; 8 <= XLEN <= WBW. Registers are zero-extended on read; upper write bits are ignored.
- CNTW, $clog2(XLEN+1), width of the iteration counter (derived; not overridden).

Ports:
- clk_i  input  1  single clock for all logic
- reset_ni  input  1  asynchronous assert, active-low reset; deassertion is synchronised externally
- wbs_stb_i  input  1  Wishbone strobe
- wbs_cyc_i  input  1  Wishbone cycle
- wbs_we_i  input  1  write enable
- wbs_sel_i  input  WBW/8  byte selects; honoured on writes
- wbs_adr_i  input  WBW  byte address; only bits [4:2] are decoded
- wbs_dat_i  input  WBW  write data
- wbs_ack_o  output  1  registered acknowledge
- wbs_dat_o  output  WBW  read data
- irq_o  output  1  done interrupt, level
- la_data_o  output  4*XLEN  {dividend, divisor, quotient, remainder}

Behaviour:
- Register map (adr[4:2]):
  - 0 DIVIDEND, RW
  - 1 DIVISOR, RW
  - 2 CTRL, RW: bit0 START (write-only, reads 0), bit1 SIGNED, bit2 IRQ_EN
  - 3 STATUS: bit0 BUSY (RO), bit1 DONE (W1C), bit2 DIV0 (W1C), bit3 OVF (W1C)
  - 4 QUOTIENT, RO
  - 5 REMAINDER, RO
  - 6-7 unmapped: acked, read 0, writes dropped.
- Handshake:
  - valid = cyc & stb. When valid is sampled high at edge E with ack low, ack_o is high for the cycle after E, then low for at least one cycle.
  - A write commits at edge E. wbs_dat_o is registered at E and valid while ack_o is high; otherwise 0.
  - No wait states; back-to-back requests complete every 2 cycles.
- While BUSY:
  - Writes to DIVIDEND, DIVISOR and CTRL are acked but ignored; a START write while busy is ignored.
  - QUOTIENT/REMAINDER return the previous result. STATUS W1C writes still apply.
- State machine IDLE -> CALC -> FIX -> IDLE:
  - IDLE: START=1 accepted at E. Latch operands. Clear DONE, DIV0 and OVF. In signed mode, take the magnitudes of the operands and record the result signs. BUSY=1 from the cycle after E. Counter = XLEN.
  - CALC: restoring shift/subtract, one bit per cycle, exactly XLEN cycles; the counter decrements to 0.
  - FIX: one cycle. Apply the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign). Apply the special cases. Write QUOTIENT/REMAINDER, set DONE, clear BUSY.
  - Total latency: START commit to DONE visible = XLEN+1 cycles, independent of operands.
- Special cases (uniform latency):
  - Divisor 0: quotient = all ones, remainder = dividend, DIV0=1.
  - Signed, dividend = most-negative and divisor = -1: quotient = dividend, remainder = 0, OVF=1.
- irq_o = DONE & IRQ_EN, combinational from registers. Clearing DONE or IRQ_EN deasserts it the next cycle.
- Simultaneous events:
  - W1C of DONE in the same cycle FIX sets DONE: the set wins.
  - START at the edge FIX completes is impossible, because BUSY blocks it until IDLE.
- Reset:
  - Values: all registers 0, state IDLE, ack_o 0, wbs_dat_o 0, irq_o 0, la_data_o 0.
  - Reset mid-calculation aborts immediately; no partial result is retained.
- la_data_o reflects the latched operand registers and the result registers continuously.

Test Plan:
- Unsigned: DIVIDEND=100, DIVISOR=7, CTRL=0x1 -> BUSY for XLEN+1 cycles, then QUOTIENT=14, REMAINDER=2, DONE=1, DIV0=0, OVF=0.
- Signed: -7 (0xFFFFFFF9) / 2, CTRL=0x3 -> QUOTIENT=0xFFFFFFFD, REMAINDER=0xFFFFFFFF; unsigned mode with the same operands -> QUOTIENT=0x7FFFFFFC, REMAINDER=1.
- Edge cases: 5/0 -> QUOTIENT=0xFFFFFFFF, REMAINDER=5, DIV0=1. Signed 0x80000000/0xFFFFFFFF -> QUOTIENT=0x80000000, REMAINDER=0, OVF=1. Both at latency XLEN+1.
- Busy protection: START 1000/3, then mid-run write DIVISOR=9 and START again -> both acked; result 333 r 1; DIVISOR reads 3.
- IRQ and W1C: IRQ_EN=1, run 10/2 -> irq_o rises with DONE. Write STATUS=0x2 -> irq_o low the next cycle. A W1C coinciding with FIX leaves DONE=1.
- Reset and handshake: drop reset_ni at CALC cycle 5 -> all outputs 0 and state IDLE. Held-high cyc/stb gives ack pulses every 2 cycles. Unmapped address 0x1C reads 0.

Source files
------------

// File: rtl/wb_serial_divider_v2.sv
// Purpose: Wishbone-mapped iterative divider, one quotient bit per clock, signed/unsigned, with IRQ.
// Latency: START write commit to DONE visible is XLEN+1 cycles, independent of operands.
// Backpressure: none; each access is acked the cycle after it is sampled, so back-to-back requests complete every 2 cycles.
//
// Ports:
//   clk_i, reset_ni           clock and asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i      Wishbone request qualifiers
//   wbs_sel_i, wbs_adr_i      byte selects (writes only), byte address (bits [4:2] decoded)
//   wbs_dat_i / wbs_dat_o     write data in / registered read data out
//   wbs_ack_o                 registered single-cycle acknowledge
//   irq_o                     level interrupt = DONE & IRQ_EN
//   la_data_o                 {DIVIDEND, DIVISOR, QUOTIENT, REMAINDER}
module wb_serial_divider_v2 #(
  parameter  int WBW  = 32,
  parameter  int XLEN = 32,
  localparam int CNTW = $clog2(XLEN + 1)
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [WBW/8-1:0]    wbs_sel_i,
  input  logic [WBW-1:0]      wbs_adr_i,
  input  logic [WBW-1:0]      wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [WBW-1:0]      wbs_dat_o,
  output logic                irq_o,
  output logic [4*XLEN-1:0]   la_data_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Software-visible registers
  logic [XLEN-1:0] r_dividend;
  logic [XLEN-1:0] r_divisor;
  logic [XLEN-1:0] r_quotient;
  logic [XLEN-1:0] r_remainder;
  logic            r_signed;
  logic            r_irq_en;
  logic            r_done;
  logic            r_div0;
  logic            r_ovf;

  // Bus interface registers
  logic            r_ack;
  logic [WBW-1:0]  r_dat;

  // Working datapath of the iteration
  logic [XLEN-1:0] r_acc;        // partial remainder
  logic [XLEN-1:0] r_dq;         // dividend bits shift out at the top, quotient bits shift in at the bottom
  logic [XLEN-1:0] r_dvs;        // divisor magnitude
  logic [CNTW-1:0] r_cnt;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_div0_case;
  logic            r_ovf_case;

  // Bus decode
  logic            w_valid;
  logic            w_accept;
  logic            w_wr;
  logic            w_rd;
  logic [2:0]      w_idx;
  logic            w_busy;
  logic [WBW-1:0]  w_bmask;
  logic [WBW-1:0]  w_wdat_m;
  logic            w_wr_dividend;
  logic            w_wr_divisor;
  logic            w_wr_ctrl;
  logic            w_w1c;
  logic            w_start;
  logic            w_st_signed;
  logic [WBW-1:0]  w_rdata;

  // Operand preparation at START
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div0;
  logic            w_ovf;

  // One restoring step
  logic [XLEN:0]   w_trial;
  logic [XLEN:0]   w_sub;
  logic            w_qbit;
  logic [XLEN-1:0] w_acc_nxt;

  // Final correction
  logic [XLEN-1:0] w_fix_q;
  logic [XLEN-1:0] w_fix_r;
  logic            w_unused;

  assign w_valid  = wbs_cyc_i & wbs_stb_i;
  // ack low is required before a new request is taken, which forces the idle cycle between accesses
  assign w_accept = w_valid & ~r_ack;
  assign w_wr     = w_accept & wbs_we_i;
  assign w_rd     = w_accept & ~wbs_we_i;
  assign w_idx    = wbs_adr_i[4:2];
  assign w_busy   = (r_state != S_IDLE);

  always_comb begin
    w_bmask = '0;
    for (int i = 0; i < WBW/8; i++) begin
      w_bmask[i*8 +: 8] = {8{wbs_sel_i[i]}};
    end
  end

  assign w_wdat_m = wbs_dat_i & w_bmask;

  // Operand and control writes are frozen while a calculation is in flight
  assign w_wr_dividend = w_wr && (w_idx == 3'd0) && !w_busy;
  assign w_wr_divisor  = w_wr && (w_idx == 3'd1) && !w_busy;
  assign w_wr_ctrl     = w_wr && (w_idx == 3'd2) && !w_busy;
  // Status clears are honoured even while busy
  assign w_w1c         = w_wr && (w_idx == 3'd3) && wbs_sel_i[0];
  assign w_start       = w_wr_ctrl && wbs_sel_i[0] && wbs_dat_i[0];
  // The SIGNED bit written together with START governs this operation
  assign w_st_signed   = wbs_sel_i[0] ? wbs_dat_i[1] : r_signed;

  assign w_a_neg = w_st_signed & r_dividend[XLEN-1];
  assign w_b_neg = w_st_signed & r_divisor[XLEN-1];
  assign w_a_mag = w_a_neg ? -r_dividend : r_dividend;
  assign w_b_mag = w_b_neg ? -r_divisor  : r_divisor;
  assign w_div0  = (r_divisor == '0);
  assign w_ovf   = w_st_signed && (r_dividend == {1'b1, {(XLEN-1){1'b0}}}) && (r_divisor == '1);

  assign w_trial   = {r_acc, r_dq[XLEN-1]};
  assign w_sub     = w_trial - {1'b0, r_dvs};
  assign w_qbit    = ~w_sub[XLEN];
  assign w_acc_nxt = w_qbit ? w_sub[XLEN-1:0] : w_trial[XLEN-1:0];

  // Special cases override the iterated result; the iteration still runs so latency is uniform
  always_comb begin
    w_fix_q = r_neg_q ? -r_dq  : r_dq;
    w_fix_r = r_neg_r ? -r_acc : r_acc;
    if (r_div0_case) begin
      w_fix_q = '1;
      w_fix_r = r_dividend;
    end else if (r_ovf_case) begin
      w_fix_q = r_dividend;
      w_fix_r = '0;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      3'd0: w_rdata[XLEN-1:0] = r_dividend;
      3'd1: w_rdata[XLEN-1:0] = r_divisor;
      3'd2: w_rdata[2:0]      = {r_irq_en, r_signed, 1'b0};
      3'd3: w_rdata[3:0]      = {r_ovf, r_div0, r_done, w_busy};
      3'd4: w_rdata[XLEN-1:0] = r_quotient;
      3'd5: w_rdata[XLEN-1:0] = r_remainder;
      default: w_rdata = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_CALC;
      S_CALC: if (r_cnt == CNTW'(1)) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus response
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_accept;
      r_dat <= w_rd ? w_rdata : '0;
    end
  end

  // Software registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_signed    <= 1'b0;
      r_irq_en    <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_done      <= 1'b0;
      r_div0      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_wr_dividend) begin
        r_dividend <= (r_dividend & ~w_bmask[XLEN-1:0]) | w_wdat_m[XLEN-1:0];
      end
      if (w_wr_divisor) begin
        r_divisor <= (r_divisor & ~w_bmask[XLEN-1:0]) | w_wdat_m[XLEN-1:0];
      end
      if (w_wr_ctrl && wbs_sel_i[0]) begin
        r_signed <= wbs_dat_i[1];
        r_irq_en <= wbs_dat_i[2];
      end

      if (r_state == S_FIX) begin
        r_quotient  <= w_fix_q;
        r_remainder <= w_fix_r;
      end

      // A completion set beats a simultaneous W1C
      if (r_state == S_FIX) begin
        r_done <= 1'b1;
      end else if (w_start || (w_w1c && wbs_dat_i[1])) begin
        r_done <= 1'b0;
      end

      if ((r_state == S_FIX) && r_div0_case) begin
        r_div0 <= 1'b1;
      end else if (w_start || (w_w1c && wbs_dat_i[2])) begin
        r_div0 <= 1'b0;
      end

      if ((r_state == S_FIX) && r_ovf_case) begin
        r_ovf <= 1'b1;
      end else if (w_start || (w_w1c && wbs_dat_i[3])) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Iteration datapath
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_acc       <= '0;
      r_dq        <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_div0_case <= 1'b0;
      r_ovf_case  <= 1'b0;
    end else if (w_start) begin
      r_acc       <= '0;
      r_dq        <= w_a_mag;
      r_dvs       <= w_b_mag;
      r_cnt       <= CNTW'(XLEN);
      r_neg_q     <= w_a_neg ^ w_b_neg;
      r_neg_r     <= w_a_neg;
      r_div0_case <= w_div0;
      r_ovf_case  <= w_ovf & ~w_div0;
    end else if (r_state == S_CALC) begin
      r_acc <= w_acc_nxt;
      r_dq  <= {r_dq[XLEN-2:0], w_qbit};
      r_cnt <= r_cnt - CNTW'(1);
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign irq_o     = r_done & r_irq_en;
  assign la_data_o = {r_dividend, r_divisor, r_quotient, r_remainder};

  assign w_unused = ^{wbs_adr_i[WBW-1:5], wbs_adr_i[1:0], w_wdat_m, w_bmask};

endmodule

// File: tb/tb_wb_serial_divider_v2.sv
// Purpose: self-checking bench for wb_serial_divider_v2 (vector table, corner sequences, random vs. arithmetic model).
// Latency: expects DONE XLEN+1 cycles after the START write commits.
// Backpressure: drives one Wishbone access at a time and waits (bounded) for its ack.
module tb_wb_serial_divider_v2;

  localparam int XLEN = 32;
  localparam logic [31:0] A_DVD  = 32'h00;
  localparam logic [31:0] A_DVS  = 32'h04;
  localparam logic [31:0] A_CTRL = 32'h08;
  localparam logic [31:0] A_STAT = 32'h0C;
  localparam logic [31:0] A_Q    = 32'h10;
  localparam logic [31:0] A_R    = 32'h14;

  logic         clk_i = 1'b0;
  logic         reset_ni;
  logic         wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]   wbs_sel_i;
  logic [31:0]  wbs_adr_i, wbs_dat_i;
  logic         wbs_ack_o;
  logic [31:0]  wbs_dat_o;
  logic         irq_o;
  logic [127:0] la_data_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  wb_serial_divider_v2 dut (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .irq_o     (irq_o),
    .la_data_o (la_data_o)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sg;
    logic [31:0] q;
    logic [31:0] r;
    logic        d0;
    logic        ov;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a clock edge; returns 1ns after the accepting edge
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd);
    bit got;
    got = 1'b0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = w;
    wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk_i); #1;
      if (wbs_ack_o) got = 1'b1;
    end
    rd = wbs_dat_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    chk("wb_ack", {127'b0, got}, 128'd1);
  endtask

  task automatic wb_wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, a, d, 4'hF, dummy);
  endtask

  task automatic wb_rd(input logic [31:0] a, output logic [31:0] d);
    wb_xfer(1'b0, a, 32'h0, 4'hF, d);
  endtask

  // Cycles until irq_o is seen, bounded
  task automatic wait_irq(output int lat);
    lat = 0;
    do begin
      @(posedge clk_i); #1;
      lat++;
    end while (!irq_o && lat < 100);
  endtask

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit sg,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output bit d0, output bit ov);
    int sa, sb;
    sa = a; sb = b; d0 = 1'b0; ov = 1'b0;
    if (b == 0) begin
      q = '1; r = a; d0 = 1'b1;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = '0; ov = 1'b1;
    end else if (sg) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Full operation with IRQ_EN set so that DONE is observable on irq_o
  task automatic run_and_check(input string tag, input logic [31:0] a, input logic [31:0] b, input bit sg,
                               input logic [31:0] eq, input logic [31:0] er, input bit ed0, input bit eov);
    int lat;
    logic [31:0] rd;
    wb_wr(A_DVD, a);
    wb_wr(A_DVS, b);
    wb_wr(A_CTRL, {29'b0, 1'b1, sg, 1'b1});
    wait_irq(lat);
    chk({tag, "_latency"}, 128'(lat), 128'(XLEN + 1));
    wb_rd(A_Q, rd);    chk({tag, "_quot"}, 128'(rd), 128'(eq));
    wb_rd(A_R, rd);    chk({tag, "_rem"}, 128'(rd), 128'(er));
    wb_rd(A_STAT, rd); chk({tag, "_status"}, 128'(rd), 128'({28'b0, eov, ed0, 1'b1, 1'b0}));
    chk({tag, "_la"}, la_data_o, {a, b, eq, er});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] ra, rb, rq, rr;
    bit          rs, rd0, rov;
    logic [7:0]  pat;
    int          lat;

    vecs[0] = '{a: 32'd100,        b: 32'd7,          sg: 1'b0, q: 32'd14,         r: 32'd2,          d0: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 32'hFFFF_FFF9,  b: 32'd2,          sg: 1'b1, q: 32'hFFFF_FFFD,  r: 32'hFFFF_FFFF,  d0: 1'b0, ov: 1'b0};
    vecs[2] = '{a: 32'hFFFF_FFF9,  b: 32'd2,          sg: 1'b0, q: 32'h7FFF_FFFC,  r: 32'd1,          d0: 1'b0, ov: 1'b0};
    vecs[3] = '{a: 32'd5,          b: 32'd0,          sg: 1'b0, q: 32'hFFFF_FFFF,  r: 32'd5,          d0: 1'b1, ov: 1'b0};
    vecs[4] = '{a: 32'h8000_0000,  b: 32'hFFFF_FFFF,  sg: 1'b1, q: 32'h8000_0000,  r: 32'd0,          d0: 1'b0, ov: 1'b1};

    reset_ni = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = '0; wbs_dat_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_ack", 128'(wbs_ack_o), 128'd0);
    chk("reset_dat", 128'(wbs_dat_o), 128'd0);
    chk("reset_irq", 128'(irq_o), 128'd0);
    chk("reset_la", la_data_o, 128'd0);
    reset_ni = 1'b1;
    @(posedge clk_i); #1;
    wb_rd(A_STAT, rd); chk("reset_status", 128'(rd), 128'd0);

    // Directed vectors
    for (int i = 0; i < 5; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sg,
                    vecs[i].q, vecs[i].r, vecs[i].d0, vecs[i].ov);
    end

    // Busy protection: writes and a second START during a run are acked and dropped
    run_and_check("pre_busy", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 1'b0);
    wb_wr(A_DVD, 32'd1000);
    wb_wr(A_DVS, 32'd3);
    wb_wr(A_CTRL, 32'h5);
    wb_wr(A_DVS, 32'd9);
    wb_wr(A_CTRL, 32'h1);
    wb_rd(A_Q, rd);    chk("busy_prev_quot", 128'(rd), 128'd10);
    wb_rd(A_STAT, rd); chk("busy_status", 128'(rd), 128'h1);
    wb_rd(A_DVS, rd);  chk("busy_divisor_kept", 128'(rd), 128'd3);
    wb_rd(A_CTRL, rd); chk("busy_ctrl_kept", 128'(rd), 128'h4);
    wait_irq(lat);
    chk("busy_irq_seen", 128'(irq_o), 128'd1);
    wb_rd(A_Q, rd);    chk("busy_quot", 128'(rd), 128'd333);
    wb_rd(A_R, rd);    chk("busy_rem", 128'(rd), 128'd1);
    wb_rd(A_DVS, rd);  chk("busy_divisor_after", 128'(rd), 128'd3);

    // W1C of DONE landing on the completion edge: the set wins
    wb_wr(A_DVD, 32'd10);
    wb_wr(A_DVS, 32'd2);
    wb_wr(A_CTRL, 32'h5);
    repeat (32) @(posedge clk_i);
    #1;
    wb_wr(A_STAT, 32'h2);
    chk("w1c_race_irq", 128'(irq_o), 128'd1);
    wb_rd(A_STAT, rd); chk("w1c_race_status", 128'(rd), 128'h2);
    wb_rd(A_Q, rd);    chk("w1c_race_quot", 128'(rd), 128'd5);

    // Ordinary W1C drops irq on the following cycle
    wb_wr(A_STAT, 32'h2);
    chk("w1c_irq_low", 128'(irq_o), 128'd0);
    wb_rd(A_STAT, rd); chk("w1c_status", 128'(rd), 128'd0);

    // Reset in the middle of CALC
    wb_wr(A_DVD, 32'd1000);
    wb_wr(A_DVS, 32'd3);
    wb_wr(A_CTRL, 32'h5);
    repeat (5) @(posedge clk_i);
    #1;
    reset_ni = 1'b0;
    #1;
    chk("midreset_ack", 128'(wbs_ack_o), 128'd0);
    chk("midreset_dat", 128'(wbs_dat_o), 128'd0);
    chk("midreset_irq", 128'(irq_o), 128'd0);
    chk("midreset_la", la_data_o, 128'd0);
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
    repeat (40) @(posedge clk_i);
    #1;
    chk("midreset_no_done_irq", 128'(irq_o), 128'd0);
    wb_rd(A_STAT, rd); chk("midreset_status", 128'(rd), 128'd0);
    wb_rd(A_Q, rd);    chk("midreset_quot", 128'(rd), 128'd0);
    chk("midreset_la_after", la_data_o, 128'd0);

    // Held-high cyc/stb: an ack every second cycle
    @(posedge clk_i); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = A_DVD;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i); #1;
      pat[i] = wbs_ack_o;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge clk_i); #1;
    chk("ack_pattern", 128'(pat), 128'h55);

    // Byte selects and unmapped space
    wb_wr(A_DVD, 32'h1122_3344);
    wb_xfer(1'b1, A_DVD, 32'hAABB_CCDD, 4'b0010, rd);
    wb_rd(A_DVD, rd);  chk("sel_byte1", 128'(rd), 128'h1122_CC44);
    wb_wr(32'h1C, 32'hDEAD_BEEF);
    wb_wr(32'h18, 32'hDEAD_BEEF);
    wb_rd(32'h1C, rd); chk("unmapped_read", 128'(rd), 128'd0);
    wb_rd(A_DVD, rd);  chk("unmapped_no_side", 128'(rd), 128'h1122_CC44);

    // Random operands against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      rs = 1'($urandom_range(0, 1));
      ref_div(ra, rb, rs, rq, rr, rd0, rov);
      run_and_check($sformatf("rnd%0d", n), ra, rb, rs, rq, rr, rd0, rov);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
